bus_memory_responder: RTL and testbench
=======================================

// Module: bus_memory_responder
// PURPOSE
//  Target end of the processor's memory bus: answers MR/MW requests on the 16-bit
//  address/data bus with a wait-stated, single-word read or write to on-chip RAM.
//  Sits beside the datapath at top level; the datapath initiates, this block responds.
//  Adds a ready handshake so memory latency is decoupled from the control-word sequence.
// PARAMETERS
//  ADDR_W       8        RAM depth = 2**ADDR_W words of 16 bits
//  BASE_ADDR    16'h0000 first bus address decoded; window = BASE_ADDR .. BASE_ADDR+2**ADDR_W-1
//  WAIT_STATES  1        extra cycles inserted before the access (0..15)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-high; clears FSM and outputs (not RAM)
//  address    in   16  bus address from datapath
//  wdata      in   16  write data from datapath (datapath side of databus)
//  MR         in   1   memory read request, level, held until ready seen
//  MW         in   1   memory write request, level, held until ready seen
//  rdata      out  16  read data; valid only while ready=1 and data_oe=1
//  data_oe    out  1   drive-enable for rdata onto shared databus
//  ready      out  1   one-cycle completion pulse
//  err        out  1   one-cycle error pulse, coincident with ready
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rdata=0, data_oe=0, ready=0, err=0, busy=0; wait counter=0.
//  States: IDLE, WAIT, ACCESS, RESP, HOLD (encoding from shared package).
//  IDLE: on edge E0 with MR|MW=1, latch address/wdata/op; -> WAIT (cnt=WAIT_STATES-1)
//   or -> ACCESS if WAIT_STATES=0. Latched values used thereafter; bus changes ignored.
//  WAIT: cnt decrements each edge; cnt==0 -> ACCESS.
//  ACCESS: RAM read or write performed on this edge (edge E0+WAIT_STATES+1); -> RESP.
//  RESP: ready=1 for exactly one cycle (rises E0+W+1, falls E0+W+2); for reads
//   data_oe=1 and rdata=RAM word in same cycle; -> HOLD.
//  HOLD: wait until MR=0 and MW=0 sampled, then -> IDLE. Prevents a held request
//   being executed twice. New request accepted no earlier than the edge after IDLE entry.
//  Decode: offset = latched_address - BASE_ADDR (16-bit, wrap); in window iff
//   offset < 2**ADDR_W; RAM index = offset[ADDR_W-1:0].
//  Out-of-window: no RAM access; RESP asserts ready=1, err=1, rdata=16'h0000, data_oe=0.
//  MR and MW both high at capture: treated as error (err=1 with ready), no write, no read.
//  Request dropped before ready (protocol violation): transaction still completes;
//   HOLD exits immediately since inputs already low.
//  Reset mid-transaction: immediate return to IDLE; a write whose ACCESS edge has not
//   occurred is not performed; RAM contents are preserved across reset.
//  Outputs all registered; no combinational path from bus inputs to ready/rdata.
// STRUCTURE
//  Package processor_bus_pkg: bus_state_t enum (IDLE,WAIT,ACCESS,RESP,HOLD),
//   DATA_W=16, BUS_ADDR_W=16 constants; shared with datapath/ControlUnit bus logic.
//  Sub-module memory_array: single-port sync RAM (clk, we, addr[ADDR_W], din, dout),
//   no reset; responder FSM, decode and wait counter stay in this module.
// TESTING
//  Write/read: W=1, MW addr 16'h0005 wdata 16'hBEEF, then MR 16'h0005 -> ready on
//   E0+2 each, rdata=16'hBEEF with data_oe=1, err=0.
//  Latency sweep W=0,1,3: ready rises exactly E0+W+1, single-cycle width, busy high E0..HOLD exit.
//  Held request: keep MR high 5 cycles after ready -> exactly one ready pulse, stays in HOLD
//   until MR falls, next request accepted the edge after IDLE entry.
//  Out-of-window: BASE_ADDR=16'h1000, MR addr 16'h0FFF and 16'h1100 (ADDR_W=8) ->
//   ready=1, err=1, rdata=0, data_oe=0; addr 16'h10FF -> normal read.
//  MR&MW together at addr 16'h0002 holding 16'h1234 -> err=1, RAM still 16'h1234.
//  Reset asserted during WAIT of a write to 16'h0007 (old 16'hAAAA) -> outputs 0
//   immediately, readback after release returns 16'hAAAA.

Source files
------------

// File: rtl/processor_bus_pkg.sv
// Shared definitions for the processor memory bus.
// Used by the memory responder, and shared with the datapath/control-unit bus logic.
//  - bus_state_t : responder state encoding
//  - DATA_W      : bus data width
//  - BUS_ADDR_W  : bus address width
package processor_bus_pkg;

    localparam int DATA_W     = 16;
    localparam int BUS_ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ACCESS = 3'd2,
        RESP   = 3'd3,
        HOLD   = 3'd4
    } bus_state_t;

endpackage

// File: rtl/bus_memory_responder_if.sv
// Memory bus between the datapath (master) and the on-chip RAM responder (slave).
//  address/wdata/MR/MW : request side, driven by the datapath
//  rdata/data_oe       : read data and its drive-enable onto the shared databus
//  ready/err           : one-cycle completion and error pulses
//  busy                : responder is not idle
interface bus_memory_responder_if;
    import processor_bus_pkg::*;

    logic [BUS_ADDR_W-1:0] address;
    logic [DATA_W-1:0]     wdata;
    logic                  MR;
    logic                  MW;
    logic [DATA_W-1:0]     rdata;
    logic                  data_oe;
    logic                  ready;
    logic                  err;
    logic                  busy;

    modport master (
        output address, wdata, MR, MW,
        input  rdata, data_oe, ready, err, busy
    );

    modport slave (
        input  address, wdata, MR, MW,
        output rdata, data_oe, ready, err, busy
    );
endinterface

// File: rtl/memory_array.sv
// Single-port synchronous RAM, one read-or-write per clock, registered read data.
// No reset: contents survive a responder reset.
//  clk  : clock
//  we   : write enable
//  addr : word index
//  din  : write data
//  dout : registered read data (old contents on a write cycle)
module memory_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // RAM write port and registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
        dout <= mem_r[addr];
    end

endmodule

// File: rtl/bus_memory_responder.sv
// Target end of the processor memory bus: answers MR/MW with a wait-stated
// single-word access to on-chip RAM and a one-cycle ready (and err) pulse.
// The request is latched in IDLE; later bus changes are ignored. After the
// response the FSM parks in HOLD until both requests are seen low, so a held
// request is never executed twice.
//  clk   : system clock
//  reset : asynchronous, active-high; clears FSM and outputs, not the RAM
//  bus   : slave side of bus_memory_responder_if
module bus_memory_responder
    import processor_bus_pkg::*;
#(
    parameter int              ADDR_W      = 8,
    parameter logic [15:0]     BASE_ADDR   = 16'h0000,
    parameter int              WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    bus_memory_responder_if.slave  bus
);

    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    bus_state_t            state_r;
    bus_state_t            state_nxt_s;
    logic [BUS_ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0]     wdata_r;
    logic                  rd_r;
    logic                  wr_r;
    logic [3:0]            cnt_r;

    logic [BUS_ADDR_W-1:0] offset_s;
    logic                  in_window_s;
    logic                  txn_err_s;
    logic                  do_write_s;
    logic                  do_read_s;
    logic                  capture_s;
    logic [ADDR_W-1:0]     ram_idx_s;
    logic [DATA_W-1:0]     ram_dout_s;

    logic                  ready_nxt_s;
    logic                  err_nxt_s;
    logic                  oe_nxt_s;
    logic                  ready_r;
    logic                  err_r;
    logic                  data_oe_r;
    logic                  busy_r;

    assign capture_s = (state_r == IDLE) && (bus.MR || bus.MW);

    // Address decode of the latched request; window test is done one bit wider
    // so a full 16-bit window still compares correctly.
    always_comb begin
        offset_s    = addr_r - BASE_ADDR;
        in_window_s = ({1'b0, offset_s} < (17'd1 << ADDR_W));
        ram_idx_s   = offset_s[ADDR_W-1:0];
        txn_err_s   = !in_window_s || (rd_r && wr_r);
        do_write_s  = (state_r == ACCESS) && wr_r && !txn_err_s;
        do_read_s   = rd_r && !txn_err_s;
    end

    // Request capture and wait-state counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= {BUS_ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            cnt_r   <= 4'd0;
        end else if (capture_s) begin
            addr_r  <= bus.address;
            wdata_r <= bus.wdata;
            rd_r    <= bus.MR;
            wr_r    <= bus.MW;
            cnt_r   <= WS_INIT;
        end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
            cnt_r   <= cnt_r - 4'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.MR || bus.MW) begin
                    state_nxt_s = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            ACCESS:  state_nxt_s = RESP;
            RESP:    state_nxt_s = HOLD;
            HOLD: begin
                if (!bus.MR && !bus.MW) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode: response flags are loaded on the ACCESS edge so they
    // are visible for exactly the RESP cycle.
    always_comb begin
        ready_nxt_s = 1'b0;
        err_nxt_s   = 1'b0;
        oe_nxt_s    = 1'b0;
        case (state_r)
            ACCESS: begin
                ready_nxt_s = 1'b1;
                err_nxt_s   = txn_err_s;
                oe_nxt_s    = do_read_s;
            end
            default: begin
                ready_nxt_s = 1'b0;
                err_nxt_s   = 1'b0;
                oe_nxt_s    = 1'b0;
            end
        endcase
    end

    // Registered bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            ready_r   <= ready_nxt_s;
            err_r     <= err_nxt_s;
            data_oe_r <= oe_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
        end
    end

    memory_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk  (clk),
        .we   (do_write_s),
        .addr (ram_idx_s),
        .din  (wdata_r),
        .dout (ram_dout_s)
    );

    // RAM read register gated by the registered enable, so rdata is zero
    // whenever it is not being driven.
    assign bus.rdata   = data_oe_r ? ram_dout_s : {DATA_W{1'b0}};
    assign bus.data_oe = data_oe_r;
    assign bus.ready   = ready_r;
    assign bus.err     = err_r;
    assign bus.busy    = busy_r;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Self-checking bench for bus_memory_responder. Three instances:
//  0: WAIT_STATES=1, BASE 16'h0000   1: WAIT_STATES=0, BASE 16'h1000
//  2: WAIT_STATES=3, BASE 16'h0000
// Expected values come from a per-instance word-array model and the
// timing rules: ready at E0+W+1 for one cycle, busy until HOLD exit.
module tb_bus_memory_responder;

    logic clk;
    logic rst;

    logic [2:0][15:0] addr_a;
    logic [2:0][15:0] wdata_a;
    logic [2:0][15:0] rdata_a;
    logic [2:0]       mr_v;
    logic [2:0]       mw_v;
    logic [2:0]       rdy_v;
    logic [2:0]       err_v;
    logic [2:0]       oe_v;
    logic [2:0]       busy_v;

    logic [15:0] mem_m   [3][256];
    bit          valid_m [3][256];

    int n_chk;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bus_memory_responder_if bif ();

        assign bif.address = addr_a[g];
        assign bif.wdata   = wdata_a[g];
        assign bif.MR      = mr_v[g];
        assign bif.MW      = mw_v[g];
        assign rdata_a[g]  = bif.rdata;
        assign oe_v[g]     = bif.data_oe;
        assign rdy_v[g]    = bif.ready;
        assign err_v[g]    = bif.err;
        assign busy_v[g]   = bif.busy;

        bus_memory_responder #(
            .ADDR_W      (8),
            .BASE_ADDR   ((g == 1) ? 16'h1000 : 16'h0000),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bif.slave)
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    function automatic logic [15:0] base_of(input int d);
        return (d == 1) ? 16'h1000 : 16'h0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete transaction on instance d; called at a negedge with the
    // instance idle, so the next posedge is the capture edge E0. The request
    // stays up for 'hold' extra cycles after ready.
    task automatic run_txn(input int d, input bit rd, input bit wr,
                           input logic [15:0] a, input logic [15:0] wd, input int hold);
        int          w;
        int          x;
        int          pulses;
        logic [15:0] off;
        bit          inwin;
        bit          bad;
        bit          rd_ok;
        w      = ws_of(d);
        off    = a - base_of(d);
        inwin  = (off < 16'd256);
        bad    = !inwin || (rd && wr);
        rd_ok  = rd && !bad;
        pulses = 0;
        mr_v[d]    = rd;
        mw_v[d]    = wr;
        addr_a[d]  = a;
        wdata_a[d] = wd;
        for (int k = 0; k <= w + 1 + hold; k++) begin
            @(negedge clk);
            if (k == 0) begin
                // bus contents change after capture; must be ignored
                addr_a[d]  = ~a;
                wdata_a[d] = ~wd;
            end
            check_eq("busy_active", busy_v[d], 1);
            if (rdy_v[d]) pulses++;
            if (k == w + 1) begin
                check_eq("ready_at_latency", rdy_v[d], 1);
                check_eq("err", err_v[d], bad);
                check_eq("data_oe", oe_v[d], rd_ok);
                if (!rd_ok) begin
                    check_eq("rdata_zero", rdata_a[d], 16'h0000);
                end else if (valid_m[d][off[7:0]]) begin
                    check_eq("rdata", rdata_a[d], mem_m[d][off[7:0]]);
                end
            end else if (k < w + 1) begin
                check_eq("ready_early", rdy_v[d], 0);
            end
        end
        mr_v[d] = 1'b0;
        mw_v[d] = 1'b0;
        // HOLD is entered at E0+W+2 and left at the first edge seeing requests low
        x = (hold == 0) ? w + 3 : w + 2 + hold;
        for (int k = w + 2 + hold; k <= x; k++) begin
            @(negedge clk);
            if (rdy_v[d]) pulses++;
            check_eq("busy_tail", busy_v[d], (k < x));
            check_eq("oe_tail", oe_v[d], 0);
        end
        check_eq("ready_pulses", pulses, 1);
        if (wr && !bad) begin
            mem_m[d][off[7:0]]   = wd;
            valid_m[d][off[7:0]] = 1'b1;
        end
    endtask

    initial begin
        int          d;
        int          r;
        logic [15:0] a;
        n_chk   = 0;
        n_err   = 0;
        rst     = 1'b1;
        addr_a  = '0;
        wdata_a = '0;
        mr_v    = 3'b000;
        mw_v    = 3'b000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_ready", rdy_v[i], 0);
            check_eq("rst_err", err_v[i], 0);
            check_eq("rst_oe", oe_v[i], 0);
            check_eq("rst_busy", busy_v[i], 0);
            check_eq("rst_rdata", rdata_a[i], 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // write/read on W=1, then the same address on the W=0 and W=3 instances
        run_txn(0, 0, 1, 16'h0005, 16'hBEEF, 0);
        run_txn(0, 1, 0, 16'h0005, 16'h0000, 0);
        run_txn(2, 0, 1, 16'h0005, 16'hC0DE, 0);
        run_txn(2, 1, 0, 16'h0005, 16'h0000, 1);
        run_txn(1, 0, 1, 16'h1005, 16'h5A5A, 0);
        run_txn(1, 1, 0, 16'h1005, 16'h0000, 2);

        // held request: MR stays up 5 cycles past ready, then back-to-back read
        run_txn(0, 1, 0, 16'h0005, 16'h0000, 5);
        run_txn(0, 1, 0, 16'h0005, 16'h0000, 0);

        // window edges with BASE 16'h1000
        run_txn(1, 1, 0, 16'h0FFF, 16'h0000, 0);
        run_txn(1, 1, 0, 16'h1100, 16'h0000, 0);
        run_txn(1, 0, 1, 16'h1100, 16'hFFFF, 0);
        run_txn(1, 0, 1, 16'h10FF, 16'h7E57, 0);
        run_txn(1, 1, 0, 16'h10FF, 16'h0000, 0);

        // MR and MW together: error, RAM untouched
        run_txn(0, 0, 1, 16'h0002, 16'h1234, 0);
        run_txn(0, 1, 1, 16'h0002, 16'hDEAD, 0);
        run_txn(0, 1, 0, 16'h0002, 16'h0000, 0);

        // reset during the WAIT of a write on the W=3 instance
        run_txn(2, 0, 1, 16'h0007, 16'hAAAA, 0);
        mw_v[2]    = 1'b1;
        addr_a[2]  = 16'h0007;
        wdata_a[2] = 16'h5555;
        @(negedge clk);
        @(negedge clk);
        check_eq("busy_in_wait", busy_v[2], 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy_v[2], 0);
        check_eq("mid_rst_ready", rdy_v[2], 0);
        check_eq("mid_rst_err", err_v[2], 0);
        check_eq("mid_rst_oe", oe_v[2], 0);
        mw_v[2] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(2, 1, 0, 16'h0007, 16'h0000, 0);
        run_txn(0, 1, 0, 16'h0005, 16'h0000, 0);

        // randomized traffic across all instances
        for (int i = 0; i < 40; i++) begin
            d = $urandom_range(0, 2);
            if (d == 1) begin
                a = 16'h0FEC + 16'($urandom_range(0, 300));
            end else begin
                a = 16'($urandom_range(0, 15));
            end
            r = $urandom_range(0, 9);
            run_txn(d, (r >= 4), (r < 4) || (r == 9), a, 16'($urandom),
                    $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
